// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared definitions for the hazard/forwarding controller.
//   - REG_W      : register index width
//   - FWD_*      : EX operand mux select codes (3 is never driven)
//   - stage_tag_t: destination tag carried by each shadow pipeline stage
//   - tag_hits() : true when a tag is a live writer of a non-x0 register rs
package hazard_fwd_ctrl_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_RF  = 2'd0;  // register-file operand
  localparam logic [1:0] FWD_WB  = 2'd1;  // MEM/WB writeback result
  localparam logic [1:0] FWD_MEM = 2'd2;  // EX/MEM ALU result

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
  } stage_tag_t;

  function automatic logic tag_hits(stage_tag_t t, logic [REG_W-1:0] rs);
    return t.valid & t.regwrite & (t.rd != '0) & (t.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_sel_logic.sv
// Combinational forwarding comparator for one EX operand.
// Ports:
//   i_rs      : source register index of the instruction in ID
//   i_use_rs  : instruction actually reads i_rs
//   i_mem_tag : tag that will sit in MEM next cycle (current EX tag)
//   i_wb_tag  : tag that will sit in WB next cycle (current MEM tag)
//   o_sel     : forwarding select (FWD_MEM / FWD_WB / FWD_RF)
module fwd_sel_logic
  import hazard_fwd_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] i_rs,
  input  logic             i_use_rs,
  input  stage_tag_t       i_mem_tag,
  input  stage_tag_t       i_wb_tag,
  output logic [1:0]       o_sel
);

  // The younger producer (the one heading into MEM) has the newer value,
  // so it is checked first. tag_hits() already excludes x0.
  always_comb begin
    o_sel = FWD_RF;
    if (i_use_rs && tag_hits(i_mem_tag, i_rs)) begin
      o_sel = FWD_MEM;
    end else if (i_use_rs && tag_hits(i_wb_tag, i_rs)) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for a 5-stage RV32I pipeline.
// Keeps a private shadow pipeline of destination tags (EX, MEM, WB), produces
// registered EX operand forwarding selects, detects load-use hazards and
// applies branch flushes to its tag pipeline.
// Ports:
//   clk_i, rst_i             : clock, synchronous active-high reset
//   id_*_i                   : decoded fields of the instruction in ID
//   flush_i                  : taken branch/jump resolved in EX this cycle
//   fwd_a_sel_o, fwd_b_sel_o : registered EX operand mux selects
//   stall_o                  : combinational hold for PC and IF/ID
//   stall_cnt_o, flush_cnt_o : saturating event counters
//
// Handshake: there is no valid/ready flow here. id_valid_i qualifies the ID
// fields for one cycle; stall_o asks the front end to present the same ID
// instruction again next cycle, and the controller inserts a bubble in EX.
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int REG_W = hazard_fwd_ctrl_pkg::REG_W,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [REG_W-1:0] id_rd_i,
  input  logic             id_regwrite_i,
  input  logic             id_memread_i,
  input  logic             flush_i,
  output logic [1:0]       fwd_a_sel_o,
  output logic [1:0]       fwd_b_sel_o,
  output logic             stall_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  stage_tag_t       r_ex_tag;
  stage_tag_t       r_mem_tag;
  stage_tag_t       r_wb_tag;
  logic [1:0]       r_fwd_a_sel;
  logic [1:0]       r_fwd_b_sel;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  stage_tag_t w_id_tag;
  logic [1:0] w_sel_a;
  logic [1:0] w_sel_b;
  logic       w_load_use;
  logic       w_stall;
  logic       w_bubble;

  assign w_id_tag.valid    = id_valid_i;
  assign w_id_tag.rd       = id_rd_i;
  assign w_id_tag.regwrite = id_regwrite_i;
  assign w_id_tag.memread  = id_memread_i;

  fwd_sel_logic u_sel_a (
    .i_rs      (id_rs1_i),
    .i_use_rs  (id_use_rs1_i),
    .i_mem_tag (r_ex_tag),
    .i_wb_tag  (r_mem_tag),
    .o_sel     (w_sel_a)
  );

  fwd_sel_logic u_sel_b (
    .i_rs      (id_rs2_i),
    .i_use_rs  (id_use_rs2_i),
    .i_mem_tag (r_ex_tag),
    .i_wb_tag  (r_mem_tag),
    .o_sel     (w_sel_b)
  );

  // A load in EX cannot forward its data until it reaches WB, so a dependent
  // ID instruction must wait one cycle. A flush discards the ID instruction,
  // and reset clears the load, so both suppress the stall immediately.
  assign w_load_use = r_ex_tag.valid & r_ex_tag.memread & (r_ex_tag.rd != '0) &
                      (((r_ex_tag.rd == id_rs1_i) & id_use_rs1_i) |
                       ((r_ex_tag.rd == id_rs2_i) & id_use_rs2_i));
  assign w_stall    = id_valid_i & w_load_use & ~flush_i & ~rst_i;
  assign w_bubble   = w_stall | flush_i | ~id_valid_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ex_tag    <= '0;
      r_mem_tag   <= '0;
      r_wb_tag    <= '0;
      r_fwd_a_sel <= FWD_RF;
      r_fwd_b_sel <= FWD_RF;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_wb_tag    <= r_mem_tag;
      r_mem_tag   <= r_ex_tag;
      r_ex_tag    <= w_bubble ? '0 : w_id_tag;
      r_fwd_a_sel <= w_bubble ? FWD_RF : w_sel_a;
      r_fwd_b_sel <= w_bubble ? FWD_RF : w_sel_b;
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (flush_i && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign fwd_a_sel_o = r_fwd_a_sel;
  assign fwd_b_sel_o = r_fwd_b_sel;
  assign stall_o     = w_stall;
  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
module tb_hazard_fwd_ctrl;

  localparam int RW    = 5;
  localparam int CW    = 4;
  localparam int C_MAX = (1 << CW) - 1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          id_valid;
  logic [RW-1:0] id_rs1, id_rs2, id_rd;
  logic          id_use_rs1, id_use_rs2, id_regwrite, id_memread;
  logic          flush;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic          stall;
  logic [CW-1:0] stall_cnt, flush_cnt;

  hazard_fwd_ctrl #(.REG_W(RW), .CNT_W(CW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .id_valid_i    (id_valid),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_use_rs1_i  (id_use_rs1),
    .id_use_rs2_i  (id_use_rs2),
    .id_rd_i       (id_rd),
    .id_regwrite_i (id_regwrite),
    .id_memread_i  (id_memread),
    .flush_i       (flush),
    .fwd_a_sel_o   (fwd_a_sel),
    .fwd_b_sel_o   (fwd_b_sel),
    .stall_o       (stall),
    .stall_cnt_o   (stall_cnt),
    .flush_cnt_o   (flush_cnt)
  );

  // scoreboard bookkeeping
  int n_checks = 0;
  int n_errors = 0;
  logic obs_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: the in-flight instructions as a list of tags,
  // index 0 = in EX, 1 = in MEM, 2 = in WB.
  int m_v[3], m_rd[3], m_rw[3], m_mr[3];
  int m_sc, m_fc;

  function automatic int exp_sel(int rs, int use_rs);
    if (use_rs == 0 || rs == 0) return 0;
    if (m_v[0] != 0 && m_rw[0] != 0 && m_rd[0] == rs) return 2;
    if (m_v[1] != 0 && m_rw[1] != 0 && m_rd[1] == rs) return 1;
    return 0;
  endfunction

  function automatic int exp_stall();
    if (rst || !id_valid || flush) return 0;
    if (m_v[0] == 0 || m_mr[0] == 0 || m_rd[0] == 0) return 0;
    if (id_use_rs1 && m_rd[0] == int'(id_rs1)) return 1;
    if (id_use_rs2 && m_rd[0] == int'(id_rs2)) return 1;
    return 0;
  endfunction

  // drivers
  task automatic set_id(input int v, input int rs1, input int u1, input int rs2,
                        input int u2, input int rd, input int rw, input int mr);
    id_valid    = v[0];
    id_rs1      = RW'(rs1);
    id_use_rs1  = u1[0];
    id_rs2      = RW'(rs2);
    id_use_rs2  = u2[0];
    id_rd       = RW'(rd);
    id_regwrite = rw[0];
    id_memread  = mr[0];
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One clock cycle with inputs already applied (called at negedge).
  task automatic step();
    int st, ea, eb;
    #1;
    st = exp_stall();
    obs_stall = stall;
    check("stall", {31'd0, stall}, st);
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_v[i] = 0; m_rd[i] = 0; m_rw[i] = 0; m_mr[i] = 0;
      end
      ea = 0; eb = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (st != 0 || flush || !id_valid) begin
        ea = 0; eb = 0;
      end else begin
        ea = exp_sel(int'(id_rs1), int'(id_use_rs1));
        eb = exp_sel(int'(id_rs2), int'(id_use_rs2));
      end
      for (int i = 2; i > 0; i--) begin
        m_v[i] = m_v[i-1]; m_rd[i] = m_rd[i-1]; m_rw[i] = m_rw[i-1]; m_mr[i] = m_mr[i-1];
      end
      if (st != 0 || flush || !id_valid) begin
        m_v[0] = 0; m_rd[0] = 0; m_rw[0] = 0; m_mr[0] = 0;
      end else begin
        m_v[0] = 1; m_rd[0] = int'(id_rd); m_rw[0] = int'(id_regwrite); m_mr[0] = int'(id_memread);
      end
      if (st != 0 && m_sc < C_MAX) m_sc++;
      if (flush && m_fc < C_MAX) m_fc++;
    end
    @(posedge clk);
    #1;
    check("fwd_a", {30'd0, fwd_a_sel}, ea);
    check("fwd_b", {30'd0, fwd_b_sel}, eb);
    check("stall_cnt", {28'd0, stall_cnt}, m_sc);
    check("flush_cnt", {28'd0, flush_cnt}, m_fc);
    @(negedge clk);
  endtask

  task automatic do_reset();
    nop(); flush = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; nop();
    for (int i = 0; i < 3; i++) begin
      m_v[i] = 0; m_rd[i] = 0; m_rw[i] = 0; m_mr[i] = 0;
    end
    m_sc = 0; m_fc = 0;
    @(negedge clk);
    do_reset();
    check("rst_fwd_a", {30'd0, fwd_a_sel}, 0);
    check("rst_stall_cnt", {28'd0, stall_cnt}, 0);

    // EX/MEM forwarding on A, nothing on B
    set_id(1, 1, 0, 2, 0, 5, 1, 0); step();
    set_id(1, 5, 1, 6, 1, 8, 1, 0); step();
    check("t1_a", {30'd0, fwd_a_sel}, 2);
    check("t1_b", {30'd0, fwd_b_sel}, 0);
    check("t1_stall", {31'd0, obs_stall}, 0);

    // MEM/WB forwarding on B across a nop
    do_reset();
    set_id(1, 1, 0, 2, 0, 5, 1, 0); step();
    nop(); step();
    set_id(1, 3, 1, 5, 1, 9, 1, 0); step();
    check("t2_b", {30'd0, fwd_b_sel}, 1);

    // two producers of x5: the younger wins
    set_id(1, 0, 0, 0, 0, 5, 1, 0); step();
    set_id(1, 0, 0, 0, 0, 5, 1, 0); step();
    set_id(1, 5, 1, 0, 0, 10, 1, 0); step();
    check("t2_young", {30'd0, fwd_a_sel}, 2);

    // load-use: one stall, bubble, then MEM/WB forwarding
    do_reset();
    set_id(1, 0, 0, 0, 0, 7, 1, 1); step();
    set_id(1, 7, 1, 0, 0, 11, 1, 0); step();
    check("t3_stall", {31'd0, obs_stall}, 1);
    check("t3_bubble", {30'd0, fwd_a_sel}, 0);
    step();
    check("t3_restall", {31'd0, obs_stall}, 0);
    check("t3_fwd", {30'd0, fwd_a_sel}, 1);
    check("t3_cnt", {28'd0, stall_cnt}, 1);

    // flush dominates a load-use stall
    do_reset();
    set_id(1, 0, 0, 0, 0, 7, 1, 1); step();
    set_id(1, 7, 1, 0, 0, 11, 1, 0); flush = 1'b1; step();
    flush = 1'b0;
    check("t4_stall", {31'd0, obs_stall}, 0);
    check("t4_a", {30'd0, fwd_a_sel}, 0);
    check("t4_fcnt", {28'd0, flush_cnt}, 1);

    // x0 never forwards or stalls
    do_reset();
    set_id(1, 0, 0, 0, 0, 0, 1, 0); step();
    set_id(1, 0, 1, 0, 1, 4, 1, 0); step();
    check("t5_a", {30'd0, fwd_a_sel}, 0);
    set_id(1, 0, 0, 0, 0, 0, 1, 1); step();
    set_id(1, 0, 1, 0, 0, 4, 1, 0); step();
    check("t5_stall", {31'd0, obs_stall}, 0);

    // reset during a load-use stall
    do_reset();
    set_id(1, 0, 0, 0, 0, 7, 1, 1); step();
    set_id(1, 7, 1, 0, 0, 11, 1, 0); rst = 1'b1; step();
    check("t6_rst_stall", {31'd0, obs_stall}, 0);
    rst = 1'b0; step();
    check("t6_after_stall", {31'd0, obs_stall}, 0);
    check("t6_cnt", {28'd0, stall_cnt}, 0);

    // stall counter saturation
    do_reset();
    for (int k = 0; k < C_MAX + 3; k++) begin
      set_id(1, 0, 0, 0, 0, 7, 1, 1); step();
      set_id(1, 0, 0, 7, 1, 12, 1, 0); step();
      nop(); step();
    end
    check("t7_sat", {28'd0, stall_cnt}, C_MAX);

    // randomized traffic over a small register set to provoke hazards
    do_reset();
    for (int n = 0; n < 600; n++) begin
      set_id(($urandom_range(0, 7) != 0) ? 1 : 0,
             $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 2) == 0 ? 1 : 0);
      flush = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0; flush = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage RV32I pipeline.
- Tracks destination tags of the in-flight instructions in a private shadow pipeline (ID/EX, EX/MEM, MEM/WB).
- Produces registered select codes for the two EX-stage 3:1 operand forwarding muxes.
- Detects load-use hazards (one-cycle stall plus bubble) and applies branch flushes to its own tag pipeline.

Parameters:
- REG_W, 5, register index width.
- CNT_W, 32, width of the saturating stall/flush event counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- id_valid_i  in  1  ID-stage instruction valid
- id_rs1_i  in  REG_W  ID source 1 index
- id_rs2_i  in  REG_W  ID source 2 index
- id_use_rs1_i  in  1  instruction reads rs1
- id_use_rs2_i  in  1  instruction reads rs2
- id_rd_i  in  REG_W  ID destination index
- id_regwrite_i  in  1  instruction writes rd
- id_memread_i  in  1  instruction is a load
- flush_i  in  1  branch/jump resolved taken in EX this cycle
- fwd_a_sel_o  out  2  EX operand A mux select
- fwd_b_sel_o  out  2  EX operand B mux select
- stall_o  out  1  hold PC and IF/ID this cycle
- stall_cnt_o  out  CNT_W  load-use stall cycles
- flush_cnt_o  out  CNT_W  flush events

Behaviour:
- One clock; reset is synchronous and active-high.
- Select encoding: 0 = register-file operand; 1 = MEM/WB writeback result; 2 = EX/MEM ALU result; 3 = never driven.
- Tag stages: EX, MEM, WB. Each holds {valid, rd, regwrite, memread}.
- Every cycle: MEM<=EX and WB<=MEM. EX<=ID tags, or <=bubble (all zero) when stall_o or flush_i is asserted.
- Select outputs are registered. They are computed at ID for the instruction entering EX next cycle, using the tags that will sit in MEM (current EX) and WB (current MEM):
  - sel=2 if the current EX tag is valid & regwrite & rd!=0 & rd==rs & use_rs.
  - else sel=1 if the current MEM tag satisfies the same condition.
  - else sel=0.
- Priority: the younger producer wins (2 over 1).
- A source index of x0 always yields 0.
- When stall_o or flush_i, the select registers load 0 (bubble in EX).
- stall_o is combinational. It is 1 iff all of the following hold:
  - id_valid_i;
  - EX tag valid & memread & rd!=0;
  - (rd==rs1 & use_rs1) | (rd==rs2 & use_rs2);
  - !flush_i.
- Flush dominates stall: the wrong-path ID instruction is discarded, so stall_o=0.
- After a one-cycle stall the load sits in MEM and EX holds the bubble. Recomputation gives sel=1 with no second stall.
- ID reads of a register being written by WB in the same cycle are handled by register-file write-through; no select is needed.
- Counters:
  - stall_cnt_o increments every cycle stall_o=1.
  - flush_cnt_o increments every cycle flush_i=1.
  - Both saturate at all-ones (no wrap).
- Reset values: all tag stages 0, fwd_a_sel_o=fwd_b_sel_o=0, stall_o=0, both counters 0.
- Reset mid-stall clears tags, so stall_o falls in the same cycle rst_i is sampled and stays 0 the following cycle.
- id_valid_i=0 produces a bubble tag and selects 0.

Decomposition:
- Shared package holds:
  - select encoding constants FWD_RF=0, FWD_WB=1, FWD_MEM=2;
  - the stage-tag struct {valid, rd, regwrite, memread};
  - REG_W.
- One natural sub-module, fwd_sel_logic. It is a combinational comparator taking rs, use_rs and two tags and returning a 2-bit select. It is instantiated twice, for A and B.

Test Plan:
- add x5 (rd=5, regwrite) then next cycle add rs1=5, rs2=6 -> fwd_a_sel_o=2 and fwd_b_sel_o=0 in the consumer's EX cycle; stall_o stays 0.
- add x5; nop; sub rs2=5 -> fwd_b_sel_o=1. A producer targeting x5 one and two cycles back -> sel=2 (younger wins).
- lw x7, then immediately add rs1=7:
  - stall_o=1 for exactly one cycle and EX receives a bubble (sel=0);
  - next cycle fwd_a_sel_o=1;
  - stall_cnt_o=1.
- lw x7 followed by a consumer of rs1=7 while flush_i=1 in the same cycle -> stall_o=0, EX bubble, flush_cnt_o increments by 1.
- Producer with rd=0 and regwrite=1 followed by a consumer with rs1=0 -> sel=0. The same pattern with a load -> stall_o=0.
- Assert rst_i during a load-use stall -> stall_o=0, selects 0 and counters 0 one cycle later. Also force stall_cnt_o to all-ones and stall again -> value holds.
